serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 10 +
 rtl/fa_mux.sv | 17 +
 rtl/serial_add_ctrl.sv | 90 +++++++++
 tb/tb_serial_add_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_mux.sv
// 1-bit full adder built from 2:1 muxes steered by the propagate term.
module fa_mux (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  // When propagating, carry passes through; otherwise a==b decides generate/kill.
  assign sum  = p ? ~cin : cin;
  assign cout = p ? cin  : a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared fa_mux, LSB first, start/busy/done handshake.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  fa_mux u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back adds.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          res   <= {fa_sum, res[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {fa_sum, res[WIDTH-1:1]};
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) plus a WIDTH=4 exhaustive sweep.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where start is raised; drops start after acceptance
  // unless hold is set. Returns negedges until done and busy cycles seen.
  task automatic wait_done8(input bit hold, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      n++;
      if (busy) nbusy++;
    end while (!done && n < 40);
  endtask

  task automatic add8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic [8:0] exp);
    int n, nb;
    a = ia; b = ib; cin = ic; start = 1'b1;
    wait_done8(1'b0, n, nb);
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_res"}, {cout, sum}, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int n, nb, nd;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {cout, sum}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 0+0: latency and busy width
    a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
    wait_done8(1'b0, n, nb);
    chk("zero_lat", n, 9);
    chk("zero_busy", nb, 8);
    chk("zero_res", {cout, sum}, 9'h000);
    chk("zero_busy_at_done", busy, 0);
    @(negedge clk);
    chk("zero_pulse", done, 0);

    add8("ff01", 8'hFF, 8'h01, 1'b0, 9'h100);
    add8("a55a", 8'hA5, 8'h5A, 1'b1, 9'h100);
    add8("3c42", 8'h3C, 8'h42, 1'b0, 9'h07E);

    // start while busy is ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 4;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("ign_lat", n, 9);
    chk("ign_res", {cout, sum}, 9'h030);
    nd = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done) nd++; end
    chk("ign_extra_done", nd, 0);
    chk("ign_idle_busy", busy, 0);

    // async reset mid-run
    a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); start = 1'b0; end
    chk("mid_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res", {cout, sum}, 0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done || busy) nd++; end
    chk("mid_no_done", nd, 0);
    add8("post_rst", 8'h01, 8'h01, 1'b0, 9'h002);

    // back-to-back with start held high
    va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0;
    va[1] = 8'hF0; vb[1] = 8'h0F; vc[1] = 1'b1;
    va[2] = 8'h80; vb[2] = 8'h80; vc[2] = 1'b0;
    va[3] = 8'h55; vb[3] = 8'h66; vc[3] = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0]; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin a = va[k+1]; b = vb[k+1]; cin = vc[k+1]; end
      else begin a = 8'hEE; b = 8'hEE; cin = 1'b1; start = 1'b0; end
      n = 1;
      while (!done && n < 40) begin @(negedge clk); n++; end
      chk($sformatf("b2b%0d_lat", k), n, 9);
      chk($sformatf("b2b%0d_res", k), {cout, sum},
          {1'b0, va[k]} + {1'b0, vb[k]} + {8'h00, vc[k]});
    end
    @(negedge clk);
    chk("b2b_end_busy", busy, 0);

    // WIDTH=4 exhaustive sweep with hold check
    for (int i = 0; i < 512; i++) begin
      logic [4:0] prev, exp4;
      bit         moved;
      prev  = {cout4, sum4};
      moved = 1'b0;
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'h0, cin4};
      start4 = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        start4 = 1'b0;
        n++;
        if (!done4 && {cout4, sum4} !== prev) moved = 1'b1;
      end while (!done4 && n < 20);
      chk($sformatf("w4_%0d_lat", i), n, 5);
      chk($sformatf("w4_%0d_res", i), {cout4, sum4}, exp4);
      chk($sformatf("w4_%0d_hold", i), moved, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
